mdu: RTL and testbench
======================

# mdu

Multiply/divide unit in the E stage of the P6 pipelined MIPS core, sitting beside the ALU and receiving the same forwarded operands (rs → A, rt → B). It executes mult/multu/div/divu over a fixed multi-cycle latency, holds the architectural HI/LO registers, and services mthi/mtlo writes. It exposes `busy` so the hazard unit can stall md-class instructions in D; mfhi/mflo read `HI`/`LO` combinationally through the E-stage result mux.

## Interface
- MULT_CYCLES, 5, cycles `busy` stays high for mult/multu
- DIV_CYCLES, 10, cycles `busy` stays high for div/divu
- clk  input  1  system clock; all state updates on posedge
- reset  input  1  synchronous, active-high; clears all state
- A  input  32  forwarded rs operand
- B  input  32  forwarded rt operand
- MDUOp  input  4  operation select, encodings from head.v
- start  input  1  one-cycle pulse: issue MDUOp this cycle (E-stage instruction is md-class and not flushed)
- busy  output  1  high while a mult/div is in flight
- HI  output  32  architectural HI register
- LO  output  32  architectural LO register

## Operation
- State: HI, LO, counter (4 bits wide enough for DIV_CYCLES), pending HI/LO result registers, busy flag.
- start with MULT: pending {HI,LO} = signed 64-bit A×B; MULTU: unsigned 64-bit product.
- start with DIV: LO = signed quotient truncated toward zero, HI = remainder with dividend's sign; DIVU: unsigned quotient/remainder.
- Divide by zero (B == 0, DIV or DIVU): full DIV_CYCLES busy period still runs; HI/LO retain previous values at completion.
- DIV of 0x80000000 by 0xFFFFFFFF: LO = 0x80000000, HI = 0 (no trap).
- MTHI: HI ← A at the edge; MTLO: LO ← A at the edge; no busy period.
- MDU_NONE or start low: no state change.
- Any start while busy is ignored (hazard unit guarantees it does not occur; the bench checks HI/LO are unaffected).
- Results commit to HI/LO only at the end of the busy period, never earlier; mfhi/mflo during busy are stalled upstream.

## Timing
- Reset: HI = 0, LO = 0, busy = 0, counter = 0, pending = 0.
- Issue edge t0 (start=1, mult-class): operands sampled, counter ← MULT_CYCLES, busy = 1 from t0 through the cycle before t0+MULT_CYCLES.
- At edge t0+MULT_CYCLES: HI/LO ← pending, busy ← 0; a new start is accepted at that same edge (back-to-back); the second issue's operands are sampled there.
- Div-class identical with DIV_CYCLES.
- MTHI/MTLO: visible on HI/LO in the cycle after the issue edge; latency 1.
- Reset asserted mid-operation: at that edge everything returns to reset values; pending result discarded; busy = 0 next cycle.
- busy is registered (no combinational path from start); the hazard unit ORs `start` in itself.

## Structure
- head.v holds `MDU_NONE` = 0, `MDU_MULT` = 1, `MDU_MULTU` = 2, `MDU_DIV` = 3, `MDU_DIVU` = 4, `MDU_MTHI` = 5, `MDU_MTLO` = 6, next to the existing ALU op codes.
- Single module, no sub-module: arithmetic uses behavioural `*`, `/`, `%` on sign-extended/zero-extended operands at issue time; the latency counter only models timing.

## Test plan
- MULT A=0xFFFFFFFE (−2), B=3 → busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; HI/LO unchanged during busy.
- MULTU A=0xFFFFFFFF, B=2 → after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
- DIV A=0xFFFFFFF9 (−7), B=2 → after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; then DIVU A=7, B=0 issued back-to-back at the completion edge → busy continues for 10 more cycles, HI/LO unchanged afterwards.
- MTHI A=0x12345678 then MTLO A=0x9ABCDEF0 on consecutive cycles → HI/LO show values one cycle after each issue; busy never asserted.
- MULT in flight, reset asserted at cycle 3 → HI=LO=0 and busy=0 after that edge; no late commit appears at cycle 5.
- start with DIV asserted while busy from an earlier MULT (2×3) → ignored; after completion HI=0, LO=6, busy falls at the original cycle.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: MDU operation encodings shared with the decoder, and latency defaults.
package mdu_pkg;
    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MTHI  = 4'd5,
        MDU_MTLO  = 4'd6
    } mdu_op_e;
    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;
endpackage

// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit holding HI/LO; results commit only when busy ends.
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_LAT,
    parameter int DIV_CYCLES  = DIV_LAT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  MDUOp,
    input  logic        start,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    mdu_op_e     op;
    logic [3:0]  cnt;
    logic [31:0] pend_hi, pend_lo;
    logic        pend_wr;
    logic        is_signed, neg_q, neg_r, done, accept;
    logic [63:0] prod;
    logic [31:0] da, db, q, r;

    // Signed division runs on magnitudes, so INT_MIN / -1 wraps to INT_MIN instead of trapping.
    always_comb begin
        op        = mdu_op_e'(MDUOp);
        is_signed = op == MDU_MULT || op == MDU_DIV;
        prod      = {{32{is_signed & A[31]}}, A} * {{32{is_signed & B[31]}}, B};
        da        = is_signed && A[31] ? -A : A;
        db        = is_signed && B[31] ? -B : B;
        q         = db == 32'd0 ? 32'd0 : da / db;
        r         = db == 32'd0 ? 32'd0 : da % db;
        neg_q     = is_signed & (A[31] ^ B[31]);
        neg_r     = is_signed & A[31];
        done      = busy && cnt == 4'd1;
        accept    = start && (!busy || done);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            HI      <= '0;
            LO      <= '0;
            busy    <= 1'b0;
            cnt     <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
        end else begin
            if (busy)
                cnt <= cnt - 4'd1;
            if (done) begin
                busy <= 1'b0;
                if (pend_wr) begin
                    HI <= pend_hi;
                    LO <= pend_lo;
                end
            end
            if (accept) begin
                case (op)
                    MDU_MULT, MDU_MULTU: begin
                        {pend_hi, pend_lo} <= prod;
                        pend_wr            <= 1'b1;
                        cnt                <= 4'(MULT_CYCLES);
                        busy               <= 1'b1;
                    end
                    MDU_DIV, MDU_DIVU: begin
                        pend_lo <= neg_q ? -q : q;
                        pend_hi <= neg_r ? -r : r;
                        pend_wr <= B != 32'd0;
                        cnt     <= 4'(DIV_CYCLES);
                        busy    <= 1'b1;
                    end
                    MDU_MTHI: HI <= A;
                    MDU_MTLO: LO <= A;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed vectors against a 64-bit arithmetic reference model, checked every cycle.
module tb_mdu;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] A = '0, B = '0;
    logic [3:0]  MDUOp = 4'd0;
    logic        start = 1'b0;
    logic        busy;
    logic [31:0] HI, LO;

    int n_chk = 0, n_fail = 0;
    logic [31:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;
    logic        m_pwr = 1'b0;
    int          m_rem = 0;
    bit          chk_en = 1'b1;

    mdu dut (.clk(clk), .reset(reset), .A(A), .B(B), .MDUOp(MDUOp), .start(start),
             .busy(busy), .HI(HI), .LO(LO));

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic, result released once its latency has elapsed.
    task automatic model_edge();
        longint          sp, sq, sr;
        longint unsigned up;
        if (reset) begin
            m_hi = '0; m_lo = '0; m_rem = 0; m_pwr = 0; m_phi = '0; m_plo = '0;
            return;
        end
        if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0 && m_pwr) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
        end
        if (!start || m_rem > 0) return;
        case (MDUOp)
            MDU_MULT: begin
                sp = longint'($signed(A)) * longint'($signed(B));
                m_phi = sp[63:32]; m_plo = sp[31:0]; m_pwr = 1; m_rem = MULT_LAT;
            end
            MDU_MULTU: begin
                up = longint'({32'd0, A}) * longint'({32'd0, B});
                m_phi = up[63:32]; m_plo = up[31:0]; m_pwr = 1; m_rem = MULT_LAT;
            end
            MDU_DIV: begin
                m_pwr = B != 0; m_rem = DIV_LAT;
                if (B != 0) begin
                    sq = longint'($signed(A)) / longint'($signed(B));
                    sr = longint'($signed(A)) % longint'($signed(B));
                    m_plo = sq[31:0]; m_phi = sr[31:0];
                end
            end
            MDU_DIVU: begin
                m_pwr = B != 0; m_rem = DIV_LAT;
                if (B != 0) begin
                    m_plo = A / B; m_phi = A % B;
                end
            end
            MDU_MTHI: m_hi = A;
            MDU_MTLO: m_lo = A;
            default: ;
        endcase
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_busy", {31'd0, busy}, {31'd0, m_rem > 0});
            check("cyc_hi", HI, m_hi);
            check("cyc_lo", LO, m_lo);
        end
    end

    task automatic step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic st, input logic rst);
        MDUOp = op; A = a; B = b; start = st; reset = rst;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        MDUOp = MDU_NONE; start = 1'b0; reset = 1'b0;
    endtask

    task automatic idle();
        step(MDU_NONE, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 40) begin
            n++;
            idle();
        end
        if (n >= 40) check("busy_timeout", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int n;
        step(MDU_NONE, 0, 0, 0, 1);
        step(MDU_NONE, 0, 0, 0, 1);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);

        step(MDU_MULT, 32'hFFFFFFFE, 32'd3, 1, 0);
        check("mult_hold_hi", HI, 32'd0);
        wait_idle(n);
        check("mult_busy_len", n, 32'd5);
        check("mult_hi", HI, 32'hFFFFFFFF);
        check("mult_lo", LO, 32'hFFFFFFFA);
        check("model_mult_hi", m_hi, 32'hFFFFFFFF);
        check("model_mult_lo", m_lo, 32'hFFFFFFFA);

        step(MDU_MULTU, 32'hFFFFFFFF, 32'd2, 1, 0);
        wait_idle(n);
        check("multu_busy_len", n, 32'd5);
        check("multu_hi", HI, 32'h00000001);
        check("multu_lo", LO, 32'hFFFFFFFE);

        step(MDU_DIV, 32'hFFFFFFF9, 32'd2, 1, 0);
        repeat (9) idle();
        check("div_hold_lo", LO, 32'hFFFFFFFE);
        step(MDU_DIVU, 32'd7, 32'd0, 1, 0);
        check("div_lo", LO, 32'hFFFFFFFD);
        check("div_hi", HI, 32'hFFFFFFFF);
        check("model_div_lo", m_lo, 32'hFFFFFFFD);
        check("b2b_busy", {31'd0, busy}, 32'd1);
        wait_idle(n);
        check("divz_busy_len", n, 32'd10);
        check("divz_hi", HI, 32'hFFFFFFFF);
        check("divz_lo", LO, 32'hFFFFFFFD);

        step(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 1, 0);
        wait_idle(n);
        check("ovf_lo", LO, 32'h80000000);
        check("ovf_hi", HI, 32'd0);

        step(MDU_DIVU, 32'hFFFFFFFF, 32'd10, 1, 0);
        wait_idle(n);
        check("divu_lo", LO, 32'h19999999);
        check("divu_hi", HI, 32'd5);

        step(MDU_MTHI, 32'h12345678, 32'd0, 1, 0);
        check("mthi", HI, 32'h12345678);
        step(MDU_MTLO, 32'h9ABCDEF0, 32'd0, 1, 0);
        check("mtlo", LO, 32'h9ABCDEF0);
        check("mtlo_hi", HI, 32'h12345678);
        check("mt_busy", {31'd0, busy}, 32'd0);

        step(MDU_MULT, 32'd5, 32'd7, 1, 0);
        idle();
        idle();
        step(MDU_NONE, 0, 0, 0, 1);
        check("rstmid_hi", HI, 32'd0);
        check("rstmid_lo", LO, 32'd0);
        check("rstmid_busy", {31'd0, busy}, 32'd0);
        repeat (4) idle();
        check("rstmid_late_lo", LO, 32'd0);

        step(MDU_MULT, 32'd2, 32'd3, 1, 0);
        step(MDU_DIV, 32'd100, 32'd7, 1, 0);
        wait_idle(n);
        check("ign_busy_len", n + 1, 32'd5);
        check("ign_hi", HI, 32'd0);
        check("ign_lo", LO, 32'd6);
        repeat (12) idle();
        check("ign_after_lo", LO, 32'd6);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
